// File: rtl/ascon_absorb_engine_if.sv
// Handshake and status bundle of the Ascon absorb engine.
// The master side (the source) drives start, the state load and the blocks; the engine is the slave.
interface ascon_absorb_engine_if #(
  parameter int RATE = 64,
  parameter int BW   = $clog2(RATE/8+1)
);
  logic            start;
  logic            mode;
  logic [319:0]    state_i;
  logic            blk_valid;
  logic            blk_ready;
  logic [RATE-1:0] blk_data;
  logic [BW-1:0]   blk_bytes;
  logic            blk_last;
  logic            busy;
  logic            done;
  logic [319:0]    state_o;
  logic            err;

  modport master (
    output start, mode, state_i, blk_valid, blk_data, blk_bytes, blk_last,
    input  blk_ready, busy, done, state_o, err
  );

  modport slave (
    input  start, mode, state_i, blk_valid, blk_data, blk_bytes, blk_last,
    output blk_ready, busy, done, state_o, err
  );
endinterface

// File: rtl/ascon_absorb_engine.sv
// Iterative Ascon absorb engine: pads and absorbs RATE-bit blocks, then runs p^b / p^a
// ROUNDS_PER_CYCLE rounds per clock and returns the state for squeeze or encryption.
module ascon_absorb_engine #(
  parameter int RATE             = 64,
  parameter int PA               = 12,
  parameter int PB               = 12,
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic                  clk,
  input logic                  rst,
  ascon_absorb_engine_if.slave bus
);
  localparam int BW     = $clog2(RATE/8+1);
  localparam int NBYTES = RATE/8;
  localparam int R      = ROUNDS_PER_CYCLE;

  typedef enum logic [2:0] {IDLE, WAIT_BLK, PERM, PAD, FINAL} state_t;

  state_t       cur, nxt;
  logic [319:0] st;
  logic [319:0] state_o_q;
  logic         mode_q, pad_pending, last_seen, err_q, done_q, blk_ready_c;
  logic [3:0]   rnd;
  logic         proto_err, eff_full, perm_last;
  logic [RATE-1:0] padded;
  logic [3:0]   final_start;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ {56'd0, 4'hf - i, i};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] perm_step(input logic [319:0] s, input logic [3:0] i);
    logic [319:0] t;
    t = s;
    for (int r = 0; r < R; r++) t = ascon_round(t, i + 4'(r));
    return t;
  endfunction

  // A malformed block is absorbed whole, so it also suppresses masking and in-block padding.
  assign proto_err   = (!bus.blk_last && bus.blk_bytes != BW'(NBYTES)) || (bus.blk_bytes > BW'(NBYTES));
  assign eff_full    = proto_err || (bus.blk_bytes == BW'(NBYTES));
  assign perm_last   = ({1'b0, rnd} + 5'(R)) == 5'd12;
  assign final_start = mode_q ? 4'(12 - PB) : 4'(12 - PA);

  always_comb begin
    padded = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (eff_full || k < int'(bus.blk_bytes))
        padded[RATE-1-8*k -: 8] = bus.blk_data[RATE-1-8*k -: 8];
      else if (k == int'(bus.blk_bytes))
        padded[RATE-1-8*k -: 8] = 8'h80;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt         = cur;
    blk_ready_c = 1'b0;
    unique case (cur)
      IDLE:     if (bus.start) nxt = WAIT_BLK;
      WAIT_BLK: begin
        blk_ready_c = 1'b1;
        if (bus.blk_valid) nxt = PERM;
      end
      PERM:     if (perm_last) nxt = pad_pending ? PAD : (last_seen ? FINAL : WAIT_BLK);
      PAD:      nxt = PERM;
      FINAL:    nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // rnd holds the round index of the next round; every p^n ends when it reaches 12.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= '0;
      state_o_q   <= '0;
      mode_q      <= 1'b0;
      pad_pending <= 1'b0;
      last_seen   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      rnd         <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (cur)
        IDLE: if (bus.start) begin
          st          <= bus.state_i;
          mode_q      <= bus.mode;
          err_q       <= 1'b0;
          pad_pending <= 1'b0;
          last_seen   <= 1'b0;
        end
        WAIT_BLK: if (bus.blk_valid) begin
          st          <= st ^ {padded, {(320-RATE){1'b0}}};
          last_seen   <= bus.blk_last;
          pad_pending <= bus.blk_last && eff_full;
          rnd         <= (bus.blk_last && !eff_full) ? final_start : 4'(12 - PB);
          if (proto_err) err_q <= 1'b1;
        end
        PERM: begin
          st  <= perm_step(st, rnd);
          rnd <= rnd + 4'(R);
        end
        PAD: begin
          st[319:312] <= st[319:312] ^ 8'h80;
          pad_pending <= 1'b0;
          rnd         <= final_start;
        end
        FINAL: begin
          state_o_q <= st ^ {319'd0, mode_q};
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.blk_ready = blk_ready_c;
  assign bus.busy      = (cur != IDLE) || done_q;
  assign bus.done      = done_q;
  assign bus.state_o   = state_o_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ascon_absorb_engine.sv
// Randomised self-checking bench for ascon_absorb_engine against a byte-stream sponge model
// built on a table-driven Ascon permutation.
module tb_ascon_absorb_engine;
  localparam int RATE = 128;
  localparam int PA   = 12;
  localparam int PB   = 6;
  localparam int RPC  = 2;
  localparam int NB   = RATE/8;
  localparam int BW   = $clog2(NB+1);
  localparam logic [319:0] IV = 320'hee9398aadb67f03d_8bb21831c60f1002_b48a92db98d5da62_43189921b8f8e3e8_348fa5c9d525e140;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_absorb_engine_if #(.RATE(RATE), .BW(BW)) bus();

  ascon_absorb_engine #(.RATE(RATE), .PA(PA), .PB(PB), .ROUNDS_PER_CYCLE(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [RATE-1:0] blk_d[$];
  int              blk_n[$];
  logic [7:0]      msg[$];
  bit              exp_err;
  int              last_eff;

  task automatic checkOutput(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int n);
    logic [63:0] x[5];
    logic [4:0]  col;
    int          i;
    for (int j = 0; j < 5; j++) x[j] = s[319-64*j -: 64];
    for (int r = 0; r < n; r++) begin
      i = 12 - n + r;
      x[2] = x[2] ^ 64'(((15 - i) << 4) | i);
      for (int b = 0; b < 64; b++) begin
        col = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]} = col;
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Standard sponge view: pad the whole byte stream with 10*, then absorb block by block.
  function automatic logic [319:0] model_absorb(input bit md, input logic [319:0] init);
    logic [7:0]      m[$];
    logic [RATE-1:0] blk;
    logic [319:0]    s;
    int              nblk;
    m = msg;
    m.push_back(8'h80);
    while (m.size() % NB != 0) m.push_back(8'h00);
    nblk = m.size() / NB;
    s = init;
    for (int b = 0; b < nblk; b++) begin
      for (int k = 0; k < NB; k++) blk[RATE-1-8*k -: 8] = m[b*NB+k];
      s[319 -: RATE] = s[319 -: RATE] ^ blk;
      s = model_perm(s, (b == nblk-1) ? (md ? PB : PA) : PB);
    end
    if (md) s[0] = ~s[0];
    return s;
  endfunction

  task automatic buildStream(input int nblk, input int last_bytes, input int bad_idx, input int bad_bytes);
    logic [RATE-1:0] d;
    int n, eff;
    bit bad;
    blk_d.delete(); blk_n.delete(); msg.delete();
    exp_err = 1'b0;
    for (int j = 0; j < nblk; j++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      n = (j == nblk-1) ? last_bytes : NB;
      if (j == bad_idx) n = bad_bytes;
      bad = ((j != nblk-1) && n != NB) || n > NB;
      eff = bad ? NB : n;
      exp_err |= bad;
      for (int k = 0; k < eff; k++) msg.push_back(d[RATE-1-8*k -: 8]);
      if (j == nblk-1) last_eff = eff;
      blk_d.push_back(d);
      blk_n.push_back(n);
    end
  endtask

  task automatic applyStimulus(input bit md, input logic [319:0] init, input bit poke,
                               output logic [319:0] res, output int lat, output logic err_o);
    int acc, acc_prev, wait_n;
    res = '0; lat = 0; err_o = 1'b0; acc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = md; bus.state_i = init;
    @(negedge clk);
    bus.start = 1'b0; bus.mode = ~md; bus.state_i = {10{$urandom}};
    checkOutput("busy_after_start", 320'(bus.busy), 320'(1));
    checkOutput("err_cleared_by_start", 320'(bus.err), 320'(0));
    acc_prev = -1;
    for (int j = 0; j < blk_d.size(); j++) begin
      bus.blk_valid = 1'b1; bus.blk_data = blk_d[j];
      bus.blk_bytes = BW'(blk_n[j]); bus.blk_last = (j == blk_d.size()-1);
      wait_n = 0;
      while (!bus.blk_ready && wait_n < 100) begin @(negedge clk); wait_n++; end
      if (!bus.blk_ready) begin
        checkOutput("ready_timeout", 320'(0), 320'(1));
        bus.blk_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      acc = cyc;
      if (acc_prev >= 0) checkOutput("accept_gap", 320'(acc - acc_prev), 320'(PB/RPC + 1));
      acc_prev = acc;
      @(negedge clk);
      checkOutput("ready_low_in_perm", 320'(bus.blk_ready), 320'(0));
      if (poke && j == 0) begin
        bus.start = 1'b1; bus.state_i = {10{$urandom}};
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    bus.blk_valid = 1'b0;
    wait_n = 0;
    while (!bus.done && wait_n < 200) begin @(negedge clk); wait_n++; end
    if (!bus.done) begin
      checkOutput("done_timeout", 320'(0), 320'(1));
      return;
    end
    lat = cyc - acc; res = bus.state_o; err_o = bus.err;
    checkOutput("busy_at_done", 320'(bus.busy), 320'(1));
    @(negedge clk);
    checkOutput("done_single_pulse", 320'(bus.done), 320'(0));
    checkOutput("state_o_holds", bus.state_o, res);
    checkOutput("err_after_done", 320'(bus.err), 320'(exp_err));
  endtask

  task automatic runCheck(input string tag, input bit md, input logic [319:0] init, input bit poke,
                          output logic [319:0] res);
    int lat, fin, exp_lat;
    logic e;
    applyStimulus(md, init, poke, res, lat, e);
    fin = md ? PB : PA;
    exp_lat = (last_eff == NB) ? (PB/RPC + 1 + fin/RPC + 1) : (fin/RPC + 1);
    checkOutput({tag, "_state"}, res, model_absorb(md, init));
    checkOutput({tag, "_latency"}, 320'(lat), 320'(exp_lat));
    checkOutput({tag, "_err"}, 320'(e), 320'(exp_err));
  endtask

  initial begin
    logic [319:0] res;
    bus.start = 1'b0; bus.mode = 1'b0; bus.state_i = '0;
    bus.blk_valid = 1'b0; bus.blk_data = '0; bus.blk_bytes = '0; bus.blk_last = 1'b0;
    rst = 1'b1;
    #12;
    checkOutput("reset_ready", 320'(bus.blk_ready), 320'(0));
    checkOutput("reset_busy", 320'(bus.busy), 320'(0));
    checkOutput("reset_done", 320'(bus.done), 320'(0));
    checkOutput("reset_err", 320'(bus.err), 320'(0));
    checkOutput("reset_state_o", bus.state_o, 320'(0));
    @(negedge clk); rst = 1'b0;

    buildStream(1, 0, -1, 0);
    runCheck("hash_empty", 1'b0, IV, 1'b0, res);
    checkOutput("hash_empty_kat_x0", 320'(res[319:256]), 320'(64'h7346bc14f036e87a));

    buildStream(1, 3, -1, 0);
    runCheck("ad_partial3", 1'b1, IV, 1'b0, res);
    buildStream(2, NB, -1, 0);
    runCheck("hash_full_last", 1'b0, IV, 1'b0, res);
    buildStream(4, NB, -1, 0);
    runCheck("ad_four_full", 1'b1, {10{$urandom}}, 1'b0, res);

    for (int it = 0; it < 12; it++) begin
      buildStream($urandom_range(1, 4), $urandom_range(0, NB), -1, 0);
      runCheck("random", 1'($urandom_range(0, 1)), {10{$urandom}}, (it % 3) == 0, res);
    end

    buildStream(2, 20, -1, 0);
    runCheck("last_oversize", 1'b0, {10{$urandom}}, 1'b0, res);
    buildStream(3, 7, 0, 5);
    runCheck("nonlast_short", 1'b1, {10{$urandom}}, 1'b0, res);

    // Abort in the middle of a permutation, then rerun the known-answer stream.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 1'b0; bus.state_i = {10{$urandom}};
    @(negedge clk);
    bus.start = 1'b0;
    bus.blk_valid = 1'b1; bus.blk_data = {$urandom, $urandom, $urandom, $urandom};
    bus.blk_bytes = BW'(NB); bus.blk_last = 1'b0;
    @(posedge clk); #2;
    checkOutput("pre_abort_busy", 320'(bus.busy), 320'(1));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 320'(bus.busy), 320'(0));
    checkOutput("abort_done", 320'(bus.done), 320'(0));
    checkOutput("abort_ready", 320'(bus.blk_ready), 320'(0));
    checkOutput("abort_state_o", bus.state_o, 320'(0));
    checkOutput("abort_err", 320'(bus.err), 320'(0));
    @(negedge clk);
    rst = 1'b0; bus.blk_valid = 1'b0;

    buildStream(1, 0, -1, 0);
    runCheck("after_abort", 1'b0, IV, 1'b0, res);
    checkOutput("after_abort_kat_x0", 320'(res[319:256]), 320'(64'h7346bc14f036e87a));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
